// File: rtl/rggen_rtl_pkg.sv
// Shared register-generator constants: read side-effect selectors and the
// access FSM state encoding used by bit-field blocks.
package rggen_rtl_pkg;

  localparam int RGGEN_READ_ACTION_SET   = 0;
  localparam int RGGEN_READ_ACTION_CLEAR = 1;

  typedef enum logic {
    RGGEN_ACCESS_IDLE = 1'b0,
    RGGEN_ACCESS_BUSY = 1'b1
  } rggen_access_state_e;

endpackage

// File: rtl/rggen_bit_field_rsx.sv
// Read-side-effect bit field (set-on-read / clear-on-read) with hardware
// set/clear, once-per-access side effect, stable read data and overrun flags.
module rggen_bit_field_rsx
  import rggen_rtl_pkg::*;
#(
  parameter int             WIDTH          = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}},
  parameter int             READ_ACTION    = RGGEN_READ_ACTION_SET,
  parameter bit             OVERRUN_ENABLE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit_field_valid,
  input  logic [WIDTH-1:0] i_bit_field_read_mask,
  input  logic [WIDTH-1:0] i_bit_field_write_mask,
  input  logic [WIDTH-1:0] i_bit_field_write_data,
  output logic [WIDTH-1:0] o_bit_field_read_data,
  output logic [WIDTH-1:0] o_bit_field_value,
  input  logic [WIDTH-1:0] i_set,
  input  logic [WIDTH-1:0] i_clear,
  output logic [WIDTH-1:0] o_value,
  output logic             o_read_trigger,
  output logic [WIDTH-1:0] o_overrun
);

  rggen_access_state_e r_state;
  rggen_access_state_e w_next_state;
  logic [WIDTH-1:0]    r_value;
  logic [WIDTH-1:0]    r_snapshot;
  logic [WIDTH-1:0]    r_overrun;
  logic                r_read_trigger;
  logic [WIDTH-1:0]    w_value_next;
  logic [WIDTH-1:0]    w_overrun_next;
  logic                w_first_read;
  logic                w_unused;

  // Writes have no effect on this field type.
  assign w_unused = ^{i_bit_field_write_mask, i_bit_field_write_data};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RGGEN_ACCESS_IDLE: if (i_bit_field_valid)  w_next_state = RGGEN_ACCESS_BUSY;
      RGGEN_ACCESS_BUSY: if (!i_bit_field_valid) w_next_state = RGGEN_ACCESS_IDLE;
      default:                                   w_next_state = RGGEN_ACCESS_IDLE;
    endcase
  end

  assign w_first_read = (r_state == RGGEN_ACCESS_IDLE) && i_bit_field_valid &&
                        (|i_bit_field_read_mask);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    if (READ_ACTION == RGGEN_READ_ACTION_CLEAR) begin : g_rc
      assign w_value_next[b] = ((w_first_read ? 1'b0 : r_value[b]) & ~i_clear[b]) | i_set[b];
    end else begin : g_rs
      assign w_value_next[b] = w_first_read | ((r_value[b] & ~i_clear[b]) | i_set[b]);
    end

    if (OVERRUN_ENABLE) begin : g_ovr
      // A clear-on-read consumes the old value, so a set during it is not lost.
      logic w_hit;
      assign w_hit = i_set[b] & r_value[b] &
                     ~(w_first_read && (READ_ACTION == RGGEN_READ_ACTION_CLEAR));
      assign w_overrun_next[b] = w_hit | (r_overrun[b] & ~w_first_read);
    end else begin : g_no_ovr
      assign w_overrun_next[b] = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= RGGEN_ACCESS_IDLE;
      r_value        <= INITIAL_VALUE;
      r_snapshot     <= INITIAL_VALUE;
      r_overrun      <= '0;
      r_read_trigger <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_value        <= w_value_next;
      r_overrun      <= w_overrun_next;
      r_read_trigger <= w_first_read;
      if ((r_state == RGGEN_ACCESS_IDLE) && i_bit_field_valid) begin
        r_snapshot <= r_value;
      end
    end
  end

  assign o_bit_field_read_data = (r_state == RGGEN_ACCESS_BUSY) ? r_snapshot : r_value;
  assign o_bit_field_value     = r_value;
  assign o_value               = r_value;
  assign o_read_trigger        = r_read_trigger;
  assign o_overrun             = r_overrun;

endmodule

// File: tb/tb_rggen_bit_field_rsx.sv
// Scoreboard bench: driver queues hand-computed expectations per cycle, a
// monitor pops and compares them against a set-on-read and a clear-on-read instance.
module tb_rggen_bit_field_rsx;

  typedef struct {
    string      name;
    bit         sel;    // 0 = RS instance, 1 = RC instance
    logic [7:0] value;
    logic [7:0] rdata;
    logic       trig;
    logic [7:0] ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       rs_valid, rc_valid;
  logic [7:0] rs_rmask, rs_wmask, rs_wdata, rs_set, rs_clr;
  logic [7:0] rc_rmask, rc_wmask, rc_wdata, rc_set, rc_clr;
  logic [7:0] rs_rdata, rs_bfv, rs_value, rs_ovr;
  logic [7:0] rc_rdata, rc_bfv, rc_value, rc_ovr;
  logic       rs_trig, rc_trig;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rggen_bit_field_rsx #(
    .WIDTH(8), .INITIAL_VALUE(8'h00), .READ_ACTION(0), .OVERRUN_ENABLE(1'b1)
  ) u_rs (
    .i_clk(clk), .i_rst(rst),
    .i_bit_field_valid(rs_valid), .i_bit_field_read_mask(rs_rmask),
    .i_bit_field_write_mask(rs_wmask), .i_bit_field_write_data(rs_wdata),
    .o_bit_field_read_data(rs_rdata), .o_bit_field_value(rs_bfv),
    .i_set(rs_set), .i_clear(rs_clr), .o_value(rs_value),
    .o_read_trigger(rs_trig), .o_overrun(rs_ovr)
  );

  rggen_bit_field_rsx #(
    .WIDTH(8), .INITIAL_VALUE(8'h33), .READ_ACTION(1), .OVERRUN_ENABLE(1'b1)
  ) u_rc (
    .i_clk(clk), .i_rst(rst),
    .i_bit_field_valid(rc_valid), .i_bit_field_read_mask(rc_rmask),
    .i_bit_field_write_mask(rc_wmask), .i_bit_field_write_data(rc_wdata),
    .o_bit_field_read_data(rc_rdata), .o_bit_field_value(rc_bfv),
    .i_set(rc_set), .i_clear(rc_clr), .o_value(rc_value),
    .o_read_trigger(rc_trig), .o_overrun(rc_ovr)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle on the selected instance (the other idles) and queue the
  // outputs expected just after the next rising edge.
  task automatic step(input string name, input bit sel, input bit r, input bit v,
                      input logic [7:0] rmask, input logic [7:0] wmask,
                      input logic [7:0] wdata, input logic [7:0] set,
                      input logic [7:0] clr, input logic [7:0] e_value,
                      input logic [7:0] e_rdata, input logic e_trig,
                      input logic [7:0] e_ovr);
    exp_t e;
    rst = r;
    rs_valid = 1'b0; rs_rmask = '0; rs_wmask = '0; rs_wdata = '0; rs_set = '0; rs_clr = '0;
    rc_valid = 1'b0; rc_rmask = '0; rc_wmask = '0; rc_wdata = '0; rc_set = '0; rc_clr = '0;
    if (!sel) begin
      rs_valid = v; rs_rmask = rmask; rs_wmask = wmask; rs_wdata = wdata;
      rs_set = set; rs_clr = clr;
    end else begin
      rc_valid = v; rc_rmask = rmask; rc_wmask = wmask; rc_wdata = wdata;
      rc_set = set; rc_clr = clr;
    end
    e.name = name; e.sel = sel; e.value = e_value; e.rdata = e_rdata;
    e.trig = e_trig; e.ovr = e_ovr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares queued expectations shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          check({e.name, ".value"}, rs_value, e.value);
          check({e.name, ".bf_value"}, rs_bfv, e.value);
          check({e.name, ".rdata"}, rs_rdata, e.rdata);
          check({e.name, ".trig"}, {7'd0, rs_trig}, {7'd0, e.trig});
          check({e.name, ".ovr"}, rs_ovr, e.ovr);
        end else begin
          check({e.name, ".value"}, rc_value, e.value);
          check({e.name, ".bf_value"}, rc_bfv, e.value);
          check({e.name, ".rdata"}, rc_rdata, e.rdata);
          check({e.name, ".trig"}, {7'd0, rc_trig}, {7'd0, e.trig});
          check({e.name, ".ovr"}, rc_ovr, e.ovr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  localparam bit RS = 1'b0;
  localparam bit RC = 1'b1;

  initial begin
    //   name          sel r  v  rmask  wmask  wdata  set    clr    value  rdata  trg ovr
    step("rst_rs",     RS, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    step("rst_rc",     RC, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h33, 0, 8'h00);

    // RS: three-cycle read, pre-side-effect data held for the whole access
    step("rs_rd_c1",   RS, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 8'h00);
    step("rs_rd_c2",   RS, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 8'h00);
    step("rs_rd_c3",   RS, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 8'h00);
    step("rs_rd_end",  RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 8'h00);

    // RS: read beats a simultaneous clear; without a read the clear applies
    step("rs_to_0f",   RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h0F, 8'h0F, 0, 8'h00);
    step("rs_rd_clr",  RS, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h0F, 1, 8'h00);
    step("rs_rd_clr2", RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 8'h00);
    step("rs_to_0f_b", RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h0F, 8'h0F, 0, 8'h00);
    step("rs_clr_only",RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 0, 8'h00);

    // RS: write-only access is a no-op
    step("rs_wr",      RS, 0, 1, 8'h00, 8'hFF, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    step("rs_wr_end",  RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);

    // RS: overrun on a repeated set, cleared by a read; new overrun beats the clear
    step("rs_set1",    RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 0, 8'h00);
    step("rs_set1_ov", RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 0, 8'h01);
    step("rs_ov_rd",   RS, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 1, 8'h00);
    step("rs_ov_rd_e", RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 8'h00);
    step("rs_ov_win",  RS, 0, 1, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF, 1, 8'h02);
    step("rs_ov_win_e",RS, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 8'h02);

    // RC: clear 8'h33, then load 8'h5A
    step("rc_rd0",     RC, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 1, 8'h00);
    step("rc_rd0_end", RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    step("rc_set5a",   RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h5A, 8'h5A, 0, 8'h00);

    // RC: set during the first read cycle survives the clear-on-read
    step("rc_rd_set",  RC, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h5A, 1, 8'h00);
    step("rc_rd_set_e",RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 0, 8'h00);

    // RC: overrun without a read, then cleared by the next read
    step("rc_set81",   RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h81, 8'h81, 0, 8'h01);
    step("rc_ov_rd",   RC, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 1, 8'h00);
    step("rc_ov_rd_e", RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);

    // RC: set of an already-set bit during the first read is not an overrun
    step("rc_set04",   RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h04, 8'h04, 0, 8'h00);
    step("rc_rd_no_ov",RC, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h04, 8'h00, 8'h04, 8'h04, 1, 8'h00);
    step("rc_no_ov_e", RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 0, 8'h00);

    // RC: set and clear on the same bit, set wins
    step("rc_set_clr", RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h0C, 8'h0C, 0, 8'h00);

    // RC: reset in the second cycle of a read restores 8'h33
    step("rc_rr_c1",   RC, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 1, 8'h00);
    step("rc_rr_rst",  RC, 1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h33, 0, 8'h00);
    step("rc_rr_idle", RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h33, 0, 8'h00);
    step("rc_rr_rd",   RC, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 1, 8'h00);
    step("rc_rr_end",  RC, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
